// File: rtl/fp_unit_arbiter.sv
// Round-robin sequencer sharing one combinational fp32 unit among N_REQ requesters.
// Optional FP_ARB_SPECIAL_BYPASS_EN: Inf/NaN operands skip EVAL and return quiet NaN 0x7FC00000.
module fp_unit_arbiter #(
    parameter int N_REQ       = 4,
    parameter int EVAL_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [32*N_REQ-1:0]      req_x,
    output logic [N_REQ-1:0]         req_ready,
    output logic [31:0]              unit_x,
    input  logic [31:0]              unit_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t                     state_q, state_d;
    logic [IDW-1:0]             ptr_q, ptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [31:0]                op_q, op_d;
    logic [IDW-1:0]             id_q, id_d;
    logic [31:0]                res_q, res_d;

    logic [N_REQ-1:0][31:0]     req_x_arr;
    logic [IDW-1:0]             grant;
    logic                       grant_vld;
    logic [31:0]                grant_x;
    int                         idx;

    assign req_x_arr = req_x;
    assign grant_x   = req_x_arr[grant];

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int j = 0; j < N_REQ; j++) begin
            idx = int'(ptr_q) + j;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        id_d      = id_q;
        res_d     = res_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant] = 1'b1;
                    id_d             = grant;
`ifdef FP_ARB_SPECIAL_BYPASS_EN
                    // Inf/NaN never reach the unit; the held operand stays put.
                    if (grant_x[30:23] == 8'hFF) begin
                        res_d   = 32'h7FC00000;
                        state_d = RESP;
                    end else begin
                        op_d    = grant_x;
                        cnt_d   = CW'(EVAL_CYCLES - 1);
                        state_d = EVAL;
                    end
`else
                    op_d    = grant_x;
                    cnt_d   = CW'(EVAL_CYCLES - 1);
                    state_d = EVAL;
`endif
                end
            end
            EVAL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_d   = unit_result;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            id_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            id_q    <= id_d;
            res_q   <= res_d;
        end
    end

    assign unit_x    = op_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = res_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Randomized bench for fp_unit_arbiter with a behavioural cos unit and a round-robin reference model.
module tb_fp_unit_arbiter;
    localparam int N  = 4;
    localparam int EV = 4;
`ifdef FP_ARB_SPECIAL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [32*N-1:0] req_x = '0;
    logic [N-1:0]    req_ready;
    logic [31:0]     unit_x;
    logic [31:0]     unit_result;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [31:0]     rsp_data;
    logic [1:0]      rsp_id;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_ptr = 0;
    int multi_ready = 0;
    int g_id[$];
    int g_cyc[$];
    logic [31:0] g_op[$];
    int r_id[$];
    int r_cyc[$];
    logic [31:0] r_data[$];
    int exp_ord[$];

    fp_unit_arbiter #(.N_REQ(N), .EVAL_CYCLES(EV)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .unit_x(unit_x), .unit_result(unit_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-precision cosine: widen to double, $cos, truncate back.
    function automatic logic [31:0] cos_fn(input logic [31:0] x);
        logic [63:0] d;
        logic [63:0] o;
        int e;
        if (x[30:23] == 8'h00) d = {x[31], 63'd0};
        else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, x[22:0], 29'd0};
        else d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
        o = $realtobits($cos($bitstoreal(d)));
        if (o[62:52] == 11'h7FF) return {o[63], 8'hFF, 1'b1, 22'd0};
        e = int'(o[62:52]) - 896;
        if (e <= 0) return {o[63], 31'd0};
        return {o[63], e[7:0], o[51:29]};
    endfunction

    assign unit_result = cos_fn(unit_x);

    function automatic logic [31:0] model_rsp(input logic [31:0] op);
        if (BYP && op[30:23] == 8'hFF) return 32'h7FC00000;
        return cos_fn(op);
    endfunction

    function automatic int model_lat(input logic [31:0] op);
        if (BYP && op[30:23] == 8'hFF) return 1;
        return EV + 1;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        if ($urandom_range(0, 3) == 0) x[30:23] = 8'hFF;
        return x;
    endfunction

    task automatic clear_logs();
        g_id.delete(); g_cyc.delete(); g_op.delete();
        r_id.delete(); r_cyc.delete(); r_data.delete();
        multi_ready = 0;
    endtask

    // Requests served in ascending order from the fairness pointer, wrapping.
    task automatic build_order(input logic [N-1:0] mask);
        exp_ord.delete();
        for (int j = 0; j < N; j++)
            if (mask[(model_ptr + j) % N]) exp_ord.push_back((model_ptr + j) % N);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Called at a negedge after driving; logs grants and consumed responses.
    task automatic run(input int n_rsp, input int budget, input bit keep, input bit rand_ready,
                       output bit timed_out);
        int pend;
        int gid;
        pend = -1;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
            #1;
            if ($countones(req_ready) > 1) multi_ready++;
            if (rsp_valid && rsp_ready) begin
                r_id.push_back(int'(rsp_id)); r_data.push_back(rsp_data); r_cyc.push_back(cyc);
            end
            gid = -1;
            for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) gid = i;
            if (gid >= 0) begin
                g_id.push_back(gid); g_op.push_back(req_x[32*gid +: 32]); g_cyc.push_back(cyc);
                pend = gid;
            end
            if (r_id.size() >= n_rsp) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
            if (pend >= 0) begin
                if (keep) req_x[32*pend +: 32] = rand_op();
                else req_valid[pend] = 1'b0;
                pend = -1;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (unit_x !== 32'h0) begin errors++; $display("FAIL reset_unit_x got %h want 0", unit_x); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_single();
        int n;
        @(negedge clk);
        req_valid = 4'b0100; req_x[64 +: 32] = 32'h0; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
            @(negedge clk);
            n++;
        end
        checks++; if (n !== EV + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", n, EV + 1); end
        checks++; if (rsp_data !== 32'h3F800000) begin errors++; $display("FAIL single_data got %h want 3f800000", rsp_data); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id got %0d want 2", rsp_id); end
        @(negedge clk);
        model_ptr = 3;
    endtask

    task automatic test_all_four();
        logic [31:0] ops[4];
        bit to;
        ops = '{32'hC0000000, 32'h40400000, 32'h3F400000, 32'h3F800000};
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) req_x[32*i +: 32] = ops[i];
        req_valid = 4'hF; rsp_ready = 1'b1;
        build_order(4'hF);
        run(4, 100, 1'b0, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL all4_timeout got %0d rsps want 4", r_id.size()); end
        checks++; if (g_id.size() != 4) begin errors++; $display("FAIL all4_grants got %0d want 4", g_id.size()); end
        for (int i = 0; i < 4 && i < r_id.size() && i < g_id.size(); i++) begin
            checks++; if (g_id[i] != exp_ord[i]) begin errors++; $display("FAIL all4_grant[%0d] got %0d want %0d", i, g_id[i], exp_ord[i]); end
            checks++; if (r_id[i] != exp_ord[i]) begin errors++; $display("FAIL all4_id[%0d] got %0d want %0d", i, r_id[i], exp_ord[i]); end
            checks++; if (r_data[i] !== model_rsp(ops[exp_ord[i]])) begin errors++; $display("FAIL all4_data[%0d] got %h want %h", i, r_data[i], model_rsp(ops[exp_ord[i]])); end
            checks++; if (r_cyc[i] - g_cyc[i] != EV + 1) begin errors++; $display("FAIL all4_latency[%0d] got %0d want %0d", i, r_cyc[i] - g_cyc[i], EV + 1); end
            if (i > 0) begin
                checks++; if (r_cyc[i] - r_cyc[i-1] != EV + 2) begin errors++; $display("FAIL all4_spacing[%0d] got %0d want %0d", i, r_cyc[i] - r_cyc[i-1], EV + 2); end
            end
        end
        checks++; if (multi_ready != 0) begin errors++; $display("FAIL all4_onehot got %0d want 0", multi_ready); end
        model_ptr = 0;
    endtask

    task automatic test_fairness();
        bit to;
        int cur;
        @(negedge clk);
        clear_logs();
        req_x[0 +: 32] = rand_op(); req_x[32 +: 32] = rand_op();
        req_valid = 4'b0011; rsp_ready = 1'b1;
        cur = (model_ptr == 1) ? 1 : 0;
        run(6, 200, 1'b1, 1'b0, to);
        @(negedge clk);
        req_valid = '0;
        checks++; if (to || r_id.size() != 6) begin errors++; $display("FAIL fair_count got %0d want 6", r_id.size()); end
        for (int i = 0; i < r_id.size() && i < g_op.size(); i++) begin
            checks++; if (r_id[i] != cur) begin errors++; $display("FAIL fair_id[%0d] got %0d want %0d", i, r_id[i], cur); end
            checks++; if (r_data[i] !== model_rsp(g_op[i])) begin errors++; $display("FAIL fair_data[%0d] got %h want %h", i, r_data[i], model_rsp(g_op[i])); end
            cur = 1 - cur;
        end
        model_ptr = (r_id.size() > 0) ? (r_id[r_id.size()-1] + 1) % N : model_ptr;
    endtask

    task automatic test_backpressure();
        logic [31:0] op;
        int id;
        int o;
        int n;
        bit to;
        id = int'($urandom_range(0, N - 1));
        o = (id + 1) % N;
        op = rand_op();
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = '0; req_valid[id] = 1'b1; req_x[32*id +: 32] = op;
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (!rsp_valid) begin errors++; $display("FAIL bp_rsp_timeout got 0 want 1"); end
        req_valid[o] = 1'b1; req_x[32*o +: 32] = 32'h3F000000;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++; if (rsp_data !== model_rsp(op)) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", k, rsp_data, model_rsp(op)); end
            checks++; if (int'(rsp_id) != id) begin errors++; $display("FAIL bp_id[%0d] got %0d want %0d", k, rsp_id, id); end
            checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got %b want 0", k, req_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d] got %b want 1", k, busy); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'(1 << o)) begin errors++; $display("FAIL bp_next_grant got %b want %b", req_ready, 4'(1 << o)); end
        clear_logs();
        run(1, 40, 1'b0, 1'b0, to);
        checks++; if (to || r_id.size() != 1 || r_id[0] != o) begin errors++; $display("FAIL bp_follow_id got %0d rsps want id %0d", r_id.size(), o); end
        else begin
            checks++; if (r_data[0] !== model_rsp(32'h3F000000)) begin errors++; $display("FAIL bp_follow_data got %h want %h", r_data[0], model_rsp(32'h3F000000)); end
        end
        model_ptr = (o + 1) % N;
    endtask

    task automatic test_reset_mid();
        logic [31:0] op;
        logic [31:0] op3;
        bit to;
        op = $urandom; op[30:23] = 8'h80;
        op3 = $urandom; op3[30:23] = 8'h7E;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 4'b0010; req_x[32 +: 32] = op;
        @(negedge clk);
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++; if (unit_x !== op) begin errors++; $display("FAIL rmid_unit_x_eval got %h want %h", unit_x, op); end
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        checks++; if (unit_x !== 32'h0) begin errors++; $display("FAIL rmid_unit_x got %h want 0", unit_x); end
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        clear_logs();
        req_valid = 4'b1000; req_x[96 +: 32] = op3;
        run(1, 40, 1'b0, 1'b0, to);
        checks++; if (to || g_id.size() == 0 || g_id[0] != 3) begin errors++; $display("FAIL rmid_first_grant got %0d grants want id 3", g_id.size()); end
        checks++; if (r_id.size() != 1 || r_data[0] !== model_rsp(op3)) begin errors++; $display("FAIL rmid_rsp got %0d rsps want 1 with %h", r_id.size(), model_rsp(op3)); end
        model_ptr = 0;
    endtask

    task automatic test_bypass();
        logic [31:0] ux0;
        bit to;
        @(negedge clk);
        ux0 = unit_x;
        clear_logs();
        rsp_ready = 1'b1;
        req_valid = 4'b0010; req_x[32 +: 32] = 32'h7F800000;
        run(1, 40, 1'b0, 1'b0, to);
        checks++; if (to || r_id.size() != 1) begin errors++; $display("FAIL byp_count got %0d want 1", r_id.size()); end
        else begin
            checks++; if (r_data[0] !== model_rsp(32'h7F800000)) begin errors++; $display("FAIL byp_data got %h want %h", r_data[0], model_rsp(32'h7F800000)); end
            checks++; if (r_cyc[0] - g_cyc[0] != model_lat(32'h7F800000)) begin errors++; $display("FAIL byp_latency got %0d want %0d", r_cyc[0] - g_cyc[0], model_lat(32'h7F800000)); end
            checks++; if (unit_x !== (BYP ? ux0 : 32'h7F800000)) begin errors++; $display("FAIL byp_unit_x got %h want %h", unit_x, BYP ? ux0 : 32'h7F800000); end
        end
        model_ptr = 2;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        bit to;
        for (int rnd = 0; rnd < 10; rnd++) begin
            @(negedge clk);
            clear_logs();
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) req_x[32*i +: 32] = rand_op();
            req_valid = mask;
            build_order(mask);
            run(exp_ord.size(), 600, 1'b0, 1'b1, to);
            checks++; if (to || r_id.size() != exp_ord.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", rnd, r_id.size(), exp_ord.size()); end
            for (int i = 0; i < r_id.size() && i < exp_ord.size() && i < g_op.size(); i++) begin
                checks++; if (r_id[i] != exp_ord[i]) begin errors++; $display("FAIL rnd%0d_id[%0d] got %0d want %0d", rnd, i, r_id[i], exp_ord[i]); end
                checks++; if (r_data[i] !== model_rsp(g_op[i])) begin errors++; $display("FAIL rnd%0d_data[%0d] got %h want %h", rnd, i, r_data[i], model_rsp(g_op[i])); end
            end
            checks++; if (multi_ready != 0) begin errors++; $display("FAIL rnd%0d_onehot got %0d want 0", rnd, multi_ready); end
            if (exp_ord.size() > 0) model_ptr = (exp_ord[exp_ord.size()-1] + 1) % N;
            req_valid = '0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end
endmodule
